// File: rtl/reaction_pkg.sv
// Shared definitions for the start-light reaction timer blocks: FSM state
// encoding, LFSR tap mask and default seed.
package reaction_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_COUNT = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  // Taps for x^14 + x^5 + x^3 + x + 1 on a shift-left register (bits 13, 4, 2, 0)
  localparam logic [13:0] LFSR_TAP_MASK = 14'h2015;
  localparam logic [13:0] DEFAULT_SEED  = 14'h2A5B;
  localparam int          TICK_MS       = 1;

endpackage

// File: rtl/lfsr_gen.sv
// Free-running 14-bit Fibonacci LFSR with recovery from the all-zero lock-up state.
module lfsr_gen
  import reaction_pkg::*;
#(
  parameter int                LFSR_W = 14,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAP_MASK);

  if (LFSR_W != 14) begin : g_bad_width
    $error("lfsr_gen: tap mask is only defined for LFSR_W = 14");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  logic feedback;
  assign feedback = ^(q & TAPS);

  // The zero check runs regardless of en so a corrupted register never stays stuck
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (q == '0) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/random_delay_timer.sv
// Pseudo-random hold-off timer: latches MIN_DELAY plus LFSR low bits on a start
// edge, counts it down in tick strobes and then holds time_out until released.
module random_delay_timer
  import reaction_pkg::*;
#(
  parameter int                LFSR_W    = 14,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int                MIN_DELAY = 500,
  parameter int                RANGE_W   = 12,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             en_lfsr,
  input  logic             start_delay,
  output logic             time_out,
  output logic             delay_busy,
  output logic [CNT_W-1:0] delay_value
);

  if (MIN_DELAY + (2 ** RANGE_W) - 1 >= (2 ** CNT_W)) begin : g_bad_range
    $error("random_delay_timer: MIN_DELAY + 2^RANGE_W - 1 does not fit in CNT_W bits");
  end
  if (RANGE_W > LFSR_W) begin : g_bad_range_w
    $error("random_delay_timer: RANGE_W must not exceed LFSR_W");
  end

  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr;
  logic              start_q;
  logic              start_rise;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  sum_val;
  logic [CNT_W-1:0]  load_val;
  state_t            state;

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (en_lfsr),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q;
  assign start_rise  = start_delay & ~start_q;
  assign sum_val     = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_q[RANGE_W-1:0]);
  assign load_val    = (sum_val == '0) ? CNT_W'(1) : sum_val;

  // Outputs are set on the transitions so they are pure register outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      cnt         <= '0;
      time_out    <= 1'b0;
      delay_busy  <= 1'b0;
      delay_value <= '0;
    end else begin
      start_q <= start_delay;
      case (state)
        ST_IDLE: begin
          time_out <= 1'b0;
          if (start_rise) begin
            state      <= ST_LOAD;
            delay_busy <= 1'b1;
          end else begin
            delay_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          cnt         <= load_val;
          delay_value <= load_val;
          delay_busy  <= 1'b1;
          state       <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!start_delay) begin
            state      <= ST_IDLE;
            delay_busy <= 1'b0;
          end else if (tick) begin
            if (cnt == CNT_W'(1)) begin
              cnt        <= '0;
              state      <= ST_DONE;
              time_out   <= 1'b1;
              delay_busy <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (!start_delay) begin
            state    <= ST_IDLE;
            time_out <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          time_out   <= 1'b0;
          delay_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
